// File: rtl/balance_mlp_classifier.sv
// Fixed-weight two-layer integer MLP for the Balance-scale task, two register stages.
// Optional ADC_LSB_DROP_EN clears bit 0 of every feature to model a 3-bit ADC.
module balance_mlp_classifier #(
   parameter int NUM_A    = 4,
   parameter int WIDTH_A  = 4,
   parameter int OUTWIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [NUM_A*WIDTH_A-1:0]   inp,
   output logic [OUTWIDTH-1:0]        out,
   output logic                       out_valid
);

   localparam int D_W = WIDTH_A + 3;
   localparam int S_W = D_W + 2;
   localparam int H_W = D_W;

   function automatic logic [H_W-1:0] relu(input logic signed [S_W-1:0] s);
      relu = s[S_W-1] ? '0 : s[H_W-1:0];
   endfunction

   function automatic logic [OUTWIDTH-1:0] argmax3(input logic [H_W-1:0] c0,
                                                   input logic [H_W-1:0] c1,
                                                   input logic [H_W-1:0] c2);
      if (c0 >= c1 && c0 >= c2)
         argmax3 = OUTWIDTH'(0);
      else if (c1 >= c2)
         argmax3 = OUTWIDTH'(1);
      else
         argmax3 = OUTWIDTH'(2);
   endfunction

   logic [WIDTH_A-1:0]        x_p0 [NUM_A];
   logic signed [D_W-1:0]     d_p0;
   logic signed [S_W-1:0]     d_ext_p0;
   logic signed [S_W-1:0]     s0_p0, s1_p0;

   logic [H_W-1:0]            h0_p1_q, h0_p1_d;
   logic [H_W-1:0]            h1_p1_q, h1_p1_d;
   logic                      vld_p1_q, vld_p1_d;
   logic [OUTWIDTH-1:0]       cls_p2_q, cls_p2_d;
   logic                      vld_p2_q, vld_p2_d;

   // Stage 0: feature unpack and layer 1
   always_comb begin
      for (int k = 0; k < NUM_A; k++) begin
`ifdef ADC_LSB_DROP_EN
         x_p0[k] = {inp[k*WIDTH_A+1 +: WIDTH_A-1], 1'b0};
`else
         x_p0[k] = inp[k*WIDTH_A +: WIDTH_A];
`endif
      end
   end

   assign d_p0 = $signed({3'b000, x_p0[0]}) + $signed({3'b000, x_p0[1]})
               - $signed({3'b000, x_p0[2]}) - $signed({3'b000, x_p0[3]});
   assign d_ext_p0 = {{(S_W-D_W){d_p0[D_W-1]}}, d_p0};
   assign s0_p0 = (d_ext_p0 <<< 1) + d_ext_p0 - S_W'(1);
   assign s1_p0 = S_W'(0) - (d_ext_p0 <<< 1) - d_ext_p0 - S_W'(1);

   always_comb begin
      h0_p1_d  = h0_p1_q;
      h1_p1_d  = h1_p1_q;
      vld_p1_d = in_valid;
      if (in_valid) begin
         h0_p1_d = relu(s0_p0);
         h1_p1_d = relu(s1_p0);
      end
   end

   // Stage 1 -> 2: layer 2 with constant bias neuron, then argmax
   always_comb begin
      cls_p2_d = cls_p2_q;
      vld_p2_d = vld_p1_q;
      if (vld_p1_q)
         cls_p2_d = argmax3(h0_p1_q, H_W'(1), h1_p1_q);
   end

   always_ff @(posedge clk) begin
      h0_p1_q <= h0_p1_d;
      h1_p1_q <= h1_p1_d;
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         cls_p2_q <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         cls_p2_q <= cls_p2_d;
      end
   end

   assign out       = cls_p2_q;
   assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_balance_mlp_classifier.sv
// Directed bench for balance_mlp_classifier; expectations follow ADC_LSB_DROP_EN when defined.
module tb_balance_mlp_classifier;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] inp;
   logic [1:0]  out;
   logic        out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   balance_mlp_classifier #(.NUM_A(4), .WIDTH_A(4), .OUTWIDTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inp       (inp),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
      pk = {d[3:0], c[3:0], b[3:0], a[3:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single isolated sample: accept, one idle cycle, then result and pulse end.
   task automatic one_sample(input string tag, input logic [15:0] x, input int exp);
      inp = x; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check({tag, "_vld"}, int'(out_valid), 1);
      check({tag, "_out"}, int'(out), exp);
      tick();
      check({tag, "_pulse_end"}, int'(out_valid), 0);
   endtask

`ifdef ADC_LSB_DROP_EN
   localparam int EXP_3323 = 1;
`else
   localparam int EXP_3323 = 0;
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b1; inp = pk(5, 5, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_out", int'(out), 0);
         check("rst_vld", int'(out_valid), 0);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("post_rst_idle_vld", int'(out_valid), 0);
      tick();
      check("post_rst_idle_vld2", int'(out_valid), 0);

      // back-to-back L, B, R
      inp = pk(5, 5, 1, 1); in_valid = 1'b1;
      tick();
      check("b2b_lat_vld", int'(out_valid), 0);
      inp = pk(3, 2, 2, 3);
      tick();
      check("b2b_L_vld", int'(out_valid), 1);
      check("b2b_L_out", int'(out), 0);
      inp = pk(1, 1, 5, 5);
      tick();
      check("b2b_B_vld", int'(out_valid), 1);
      check("b2b_B_out", int'(out), 1);
      in_valid = 1'b0;
      tick();
      check("b2b_R_vld", int'(out_valid), 1);
      check("b2b_R_out", int'(out), 2);
      tick();
      check("b2b_end_vld", int'(out_valid), 0);
      check("b2b_hold_out", int'(out), 2);

      // margins
      one_sample("m_d_pos1", pk(3, 3, 2, 3), EXP_3323);
      one_sample("m_d_neg1", pk(3, 2, 2, 4), 2);
      one_sample("m_all15", pk(15, 15, 15, 15), 1);
      one_sample("m_0_0_15_15", pk(0, 0, 15, 15), 2);
      one_sample("m_15_15_0_0", pk(15, 15, 0, 0), 0);
      one_sample("m_5511", pk(5, 5, 1, 1), 0);

      // valid gap 1,0,1
      inp = pk(5, 5, 1, 1); in_valid = 1'b1;
      tick();
      check("gap_t1_vld", int'(out_valid), 0);
      in_valid = 1'b0; inp = pk(1, 1, 5, 5);
      tick();
      check("gap_t2_vld", int'(out_valid), 1);
      check("gap_t2_out", int'(out), 0);
      in_valid = 1'b1;
      tick();
      check("gap_t3_vld", int'(out_valid), 0);
      check("gap_t3_hold", int'(out), 0);
      in_valid = 1'b0;
      tick();
      check("gap_t4_vld", int'(out_valid), 1);
      check("gap_t4_out", int'(out), 2);
      tick();
      check("gap_t5_vld", int'(out_valid), 0);

      // reset with two samples in flight
      inp = pk(1, 1, 5, 5); in_valid = 1'b1;
      tick();
      inp = pk(3, 2, 2, 3); rst = 1'b1;
      tick();
      check("mid_rst_vld", int'(out_valid), 0);
      check("mid_rst_out", int'(out), 0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("mid_rst_flush_vld1", int'(out_valid), 0);
      tick();
      check("mid_rst_flush_vld2", int'(out_valid), 0);
      check("mid_rst_flush_out", int'(out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/balance_mlp_classifier.md
Name: balance_mlp_classifier

Overview:
- Fixed-weight, two-layer integer MLP classifier for the 4-feature Balance-scale task.
- Takes four unsigned 4-bit ADC samples packed into one bus and produces a 2-bit class index: 0 = left-heavy (L), 1 = balanced (B), 2 = right-heavy (R).
- Sits directly behind the sensor ADC front-end. The pipeline is registered, and results are qualified by a valid strobe.

Parameters:
- NUM_A, 4, number of input features. The fixed weights require 4.
- WIDTH_A, 4, bits per feature, unsigned.
- OUTWIDTH, 2, width of the class index.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies inp for the current cycle.
- inp  input  NUM_A*WIDTH_A (16)  packed features; feature k occupies bits [(k+1)*WIDTH_A-1 : k*WIDTH_A], so x0 = inp[3:0] and x3 = inp[15:12].
- out  output  OUTWIDTH (2)  class index of the most recent accepted sample.
- out_valid  output  1  one-cycle pulse marking a newly updated out.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out=0, out_valid=0, and all internal valid bits are cleared.
  - Reset wins over a simultaneous in_valid.
  - Any sample in flight when reset is applied is discarded.
- Layer 1 (combinational from inp):
  - d = x0 + x1 - x2 - x3, signed, range -30..30.
  - s0 = 3*d - 1 and s1 = -3*d - 1, signed 9-bit, range -91..89.
  - h0 = ReLU(s0), h1 = ReLU(s1), unsigned 7-bit.
- Stage 1 register:
  - When in_valid=1, h0 and h1 are captured and v1 is set to 1.
  - Otherwise v1 is set to 0 and the h registers hold their values.
- Layer 2 (from stage-1 registers): scores are c0 = h0, c1 = 1 (constant bias neuron), c2 = h1.
- Argmax:
  - Selects the index of the largest score.
  - On a tie the lowest index wins.
  - Index 3 is never produced.
- Stage 2 register:
  - When v1=1, out is set to the argmax result and out_valid is set to 1.
  - Otherwise out_valid is set to 0 and out holds its value.
- Resulting mapping: d>=1 gives 0 (L); d=0 gives 1 (B); d<=-1 gives 2 (R).
- Timing:
  - Latency is exactly 2 clock edges from the accepting edge to out_valid=1.
  - Throughput is one sample per cycle with no back-pressure.
  - Gaps in in_valid produce matching gaps in out_valid.
- Arithmetic:
  - No overflow is possible at the stated widths.
  - Features take the full 0..15 range, although the application uses 1..5.

Optional Feature:
- Macro: ADC_LSB_DROP_EN.
- When defined:
  - Bit 0 of every feature is forced to 0 before layer 1, which models a 3-bit ADC.
  - Reset, latency, and port widths are unchanged.
- When undefined: all 4 bits of each feature are used.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> out=0 and out_valid=0 on every cycle; after release out_valid stays 0 until 2 edges after the first accepted sample.
- Class coverage with samples issued back to back:
  - x=(5,5,1,1) -> out=0.
  - x=(3,2,2,3) -> out=1.
  - x=(1,1,5,5) -> out=2.
  - Each result appears 2 cycles after its input; out_valid stays high for 3 consecutive cycles.
- Margin cases:
  - x=(3,3,2,3), d=1 -> out=0.
  - x=(3,2,2,4), d=-1 -> out=2.
  - x=(15,15,15,15) -> out=1.
  - x=(0,0,15,15) -> out=2, confirming no overflow.
- Valid gaps: apply in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed by 2 cycles; out holds during the gap.
- Reset mid-stream: assert rst while two samples are in flight -> neither sample produces out_valid, and out=0.
- ADC_LSB_DROP_EN defined:
  - x=(3,3,2,3) becomes (2,2,2,2) -> out=1; the same stimulus without the macro gives out=0.
  - x=(5,5,1,1) becomes (4,4,0,0) -> out=0.
